// File: rtl/fifo_pkg.sv
// Shared FIFO sizing defaults and the wrapped pointer-advance helper used by
// the FIFO controllers in this codebase.
package fifo_pkg;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 20;
  localparam int FIFO_AW    = 8;

  // Non-power-of-two depths need an explicit wrap at depth-1.
  function automatic logic [FIFO_AW-1:0] ptr_inc(input logic [FIFO_AW-1:0] ptr,
                                                 input logic [FIFO_AW-1:0] depth);
    if (ptr == depth - FIFO_AW'(1)) return '0;
    return ptr + FIFO_AW'(1);
  endfunction

endpackage

// File: rtl/mlab_ram_sdp.sv
// Simple dual-port MLAB RAM: synchronous write, registered read (1 cycle),
// old data returned on read-during-write to the same address.
module mlab_ram_sdp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20,
  parameter int AW    = 8
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    readaddr,
  input  logic [AW-1:0]    writeaddr,
  input  logic             wren,
  input  logic             clock
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  (* ramstyle = "no_rw_check, MLAB" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wren) mem[writeaddr[IW-1:0]] <= data;
    q <= mem[readaddr[IW-1:0]];
  end

  generate
    if (AW > IW) begin : g_addr_hi
      // Upper address bits are always zero for in-range pointers.
      logic unused_addr_hi;
      assign unused_addr_hi = ^{readaddr[AW-1:IW], writeaddr[AW-1:IW]};
    end
  endgenerate

endmodule

// File: rtl/mlab_fifo_ctrl.sv
// FWFT controller around one MLAB RAM: empty write-to-out_valid 2 cycles, 1 word/cycle pops;
// in_ready is from registered count only. FIFO_STATS_EN adds hwm/drops ports.
module mlab_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
`ifdef FIFO_STATS_EN
  ,
  output logic [CW-1:0]    hwm,
  output logic [15:0]      drops
`endif
);

  localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
  localparam logic [FIFO_AW-1:0] DEPTH_P = FIFO_AW'(DEPTH);

  logic [AW-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d, rd_addr;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop;

  assign in_ready  = (count_q != DEPTH_C);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid_q & out_ready;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign out_valid = out_valid_q;

  always_comb begin
    rd_addr     = pop  ? AW'(ptr_inc(FIFO_AW'(rdptr_q), DEPTH_P)) : rdptr_q;
    wrptr_d     = push ? AW'(ptr_inc(FIFO_AW'(wrptr_q), DEPTH_P)) : wrptr_q;
    rdptr_d     = rd_addr;
    count_d     = count_q + CW'(push) - CW'(pop);
    // Only words already in the RAM before this edge may become visible.
    out_valid_d = ((count_q - CW'(pop)) != '0);
    if (clear) begin
      wrptr_d     = '0;
      rdptr_d     = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_q     <= '0;
      rdptr_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wrptr_q     <= wrptr_d;
      rdptr_q     <= rdptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  mlab_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .q         (out_data),
    .data      (in_data),
    .readaddr  (rd_addr),
    .writeaddr (wrptr_q),
    .wren      (push & ~clear),
    .clock     (clock)
  );

`ifdef FIFO_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [15:0]   drops_q, drops_d;

  always_comb begin
    hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
    drops_d = drops_q;
    if (in_valid && !in_ready && (drops_q != 16'hFFFF)) drops_d = drops_q + 16'd1;
    if (clear) begin
      hwm_d   = '0;
      drops_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q   <= '0;
      drops_q <= '0;
    end else begin
      hwm_q   <= hwm_d;
      drops_q <= drops_d;
    end
  end

  assign hwm   = hwm_q;
  assign drops = drops_q;
`endif

endmodule

// File: tb/tb_mlab_fifo_ctrl.sv
// Directed plus randomized bench for mlab_fifo_ctrl against a queue-based reference model.
module tb_mlab_fifo_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 20;
  localparam int AW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset_n;
  logic             clear;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef FIFO_STATS_EN
  logic [CW-1:0]    hwm;
  logic [15:0]      drops;
`endif

  mlab_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_STATS_EN
    ,
    .hwm       (hwm),
    .drops     (drops)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: stored words in order, visibility of the head, stats.
  logic [31:0] mq[$];
  bit          mv;
  int          mhwm;
  int          mdrops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mv     = 1'b0;
    mhwm   = 0;
    mdrops = 0;
  endtask

  task automatic check_state();
    check("count",     32'(count),     32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mv));
    check("full",      32'(full),      32'(mq.size() == DEPTH));
    check("empty",     32'(empty),     32'(mq.size() == 0));
    check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    if (mv) check("out_data", out_data, mq[0]);
`ifdef FIFO_STATS_EN
    check("hwm",   32'(hwm),   32'(mhwm));
    check("drops", 32'(drops), 32'(mdrops));
`endif
  endtask

  // One clock cycle: drive inputs, advance model by the handshake rules, check after the edge.
  task automatic step(input bit iv, input logic [31:0] id, input bit ordy, input bit clr);
    bit m_rdy, m_push, m_pop;
    int remain;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clear     = clr;
    m_rdy  = (mq.size() != DEPTH);
    m_push = iv && m_rdy;
    m_pop  = mv && ordy;
    @(posedge clock);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      if (iv && !m_rdy && mdrops < 65535) mdrops++;
      remain = mq.size() - (m_pop ? 1 : 0);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(id);
      mv = (remain != 0);
      if (mq.size() > mhwm) mhwm = mq.size();
    end
    check_state();
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_count",     32'(count),     32'd0);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_full",      32'(full),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single word latency into an empty FIFO
    step(1'b1, 32'h0000_00A5, 1'b0, 1'b0);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data",  out_data,       32'h0000_00A5);
    check("lat_count",       32'(count),     32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_a5_empty",  32'(empty),     32'd1);

    // Fill to full, then one refused push
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check("fill_full",     32'(full),     32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_count",    32'(count),    32'd20);
    step(1'b1, 32'h0000_0099, 1'b0, 1'b0);
    check("ovf_count",     32'(count),    32'd20);
`ifdef FIFO_STATS_EN
    check("ovf_drops",     32'(drops),    32'd1);
`endif

    // Drain from full: one word per cycle, no bubbles
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  out_data,       32'(i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("drained_empty", 32'(empty),     32'd1);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Sustained push+pop at count=3 across pointer wraps
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 32'd3);
    end

    // clear with simultaneous push and pop at count=7
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
    check("pre_clear_count", 32'(count), 32'd7);
    step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b1);
    check("clear_count", 32'(count),     32'd0);
    check("clear_valid", 32'(out_valid), 32'd0);
    check("clear_empty", 32'(empty),     32'd1);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("post_clear_edge1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_clear_edge2_valid", 32'(out_valid), 32'd1);
    check("post_clear_data",        out_data,       32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at count=12
    for (int i = 0; i < 12; i++) step(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd12);
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(count),     32'd0);
    check("arst_empty", 32'(empty),     32'd1);
    check("arst_valid", 32'(out_valid), 32'd0);
`ifdef FIFO_STATS_EN
    check("arst_hwm",   32'(hwm),       32'd0);
`endif
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Randomized traffic: fill-biased then drain-biased, rare clears
    for (int i = 0; i < 800; i++) begin
      bit iv, ordy, clr;
      if ((i / 100) % 2 == 0) begin
        iv   = ($urandom_range(0, 9) < 8);
        ordy = ($urandom_range(0, 9) < 4);
      end else begin
        iv   = ($urandom_range(0, 9) < 4);
        ordy = ($urandom_range(0, 9) < 8);
      end
      clr = ($urandom_range(0, 63) == 0);
      step(iv, $urandom, ordy, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mlab_fifo_ctrl.md
Name: mlab_fifo_ctrl

Overview:
- First-word-fall-through FIFO controller wrapping one 20x32 MLAB RAM (synchronous write, registered read, 1-cycle read latency, old-data read-during-write).
- Sits between the HPS-side write stream and the FPGA-side consumer; owns the RAM write/read addresses, occupancy, and the valid/ready handshakes.
- Non-power-of-two depth, so pointers wrap explicitly.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 20, RAM entries; legal range 2..255.
- AW, 8, RAM address width.
- CW, $clog2(DEPTH+1), occupancy counter width (5 at default).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- in_data  in  WIDTH  write word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  WIDTH  head word; direct from RAM read register.
- out_valid  out  1  out_data holds the head word.
- out_ready  in  1  consumer accepts the head word.
- count  out  CW  words stored (includes head).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, reset_n=0): wrptr=0, rdptr=0, count=0, out_valid=0, in_ready=1, full=0, empty=1. out_data is not reset; it is undefined until out_valid=1.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH), registered-state only. There is no combinational path from out_ready, so a push is refused when full even if a pop happens in the same cycle.
- Push: RAM wren=1, writeaddr=wrptr, data=in_data; wrptr advances.
- Pointer wrap: pointer advances DEPTH-1 -> 0; otherwise +1.
- RAM readaddr is combinational:
  - rdptr advanced by one (with wrap) when pop=1;
  - otherwise rdptr.
  - out_data therefore updates on the edge after the read address is presented.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- out_valid_next = ((count - pop) != 0).
  - This counts only words written before the current cycle, so a same-cycle write never exposes stale RAM data.
  - Write-to-out_valid latency when empty: 2 cycles.
  - Back-to-back pops sustain 1 word/cycle while count >= 2 before each pop.
- full and empty are combinational decodes of count.
- Overflow cannot occur (push is gated by in_ready). A pop with out_valid=0 is ignored.
- clear=1: next edge sets wrptr=rdptr=0, count=0, out_valid=0. Any push or pop in that cycle is discarded; RAM contents are left as-is.
- reset_n asserted mid-transfer: state drops to reset values immediately. In-flight words are lost.

Optional Feature:
- Macro FIFO_STATS_EN.
- Defined: adds output ports hwm (CW bits) and drops (16 bits).
  - hwm = maximum count since reset or clear.
  - drops increments when in_valid & !in_ready; it saturates at 16'hFFFF.
  - Both are cleared by reset_n and by clear.
- Undefined: these ports and registers are absent. Core behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - localparams FIFO_WIDTH=32, FIFO_DEPTH=20, FIFO_AW=8;
  - function ptr_inc(ptr, depth) for wrapped pointer advance, shared with other FIFO controllers.
- One sub-module: mlab_ram_sdp, the WIDTH x DEPTH MLAB RAM (ramstyle "no_rw_check, MLAB").
  - Ports: q, data, readaddr, writeaddr, wren, clock.
  - Instantiated once. The controller holds all pointer and handshake logic.

Test Plan:
- Reset, then push 1 word 0x0000_00A5 into an empty FIFO with out_ready=0 -> out_valid=0 on the 1st edge, out_valid=1 and out_data=0x0000_00A5 on the 2nd edge; count=1.
- Push 20 words 0..19 with out_ready=0 -> full=1, in_ready=0, count=20; a 21st in_valid is not accepted (drops=1 with FIFO_STATS_EN).
- From full, assert out_ready for 20 cycles with no pushes -> out_data sequence 0..19, one per cycle, no bubbles; then empty=1, out_valid=0.
- Continuous simultaneous push/pop for 50 cycles starting at count=3 -> count stays 3; pointers wrap 19->0 at least twice; output order equals input order.
- clear pulsed at count=7 together with push and pop -> next cycle count=0, out_valid=0, empty=1; the following pushed word 0xDEAD_BEEF appears at out_data 2 cycles later.
- Assert reset_n low asynchronously mid-stream at count=12 -> count=0, empty=1, out_valid=0 without waiting for a clock edge; hwm=0 with FIFO_STATS_EN.
